// File: rtl/tick_bcd_stopwatch_pkg.sv
// tick_bcd_stopwatch_pkg: shared display constants and the 7-segment encoder
package tick_bcd_stopwatch_pkg;
  localparam int DIGITS = 4;
  localparam logic [3:0] AN_IDLE = 4'b1111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0: seg_enc = SEG_0;
      4'd1: seg_enc = SEG_1;
      4'd2: seg_enc = SEG_2;
      4'd3: seg_enc = SEG_3;
      4'd4: seg_enc = SEG_4;
      4'd5: seg_enc = SEG_5;
      4'd6: seg_enc = SEG_6;
      4'd7: seg_enc = SEG_7;
      4'd8: seg_enc = SEG_8;
      4'd9: seg_enc = SEG_9;
      default: seg_enc = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/tick_bcd_stopwatch_bcd_digit.sv
// bcd_digit: one BCD decade with increment, carry out and synchronous clear
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [3:0] q_o,
  output logic       carry_o
);
  logic [3:0] q_q, q_d;
  always_comb begin
    q_d = clr_i ? 4'd0 : inc_i ? ((q_q == 4'd9) ? 4'd0 : q_q + 4'd1) : q_q;
    carry_o = inc_i & (q_q == 4'd9);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= 4'd0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/tick_bcd_stopwatch.sv
// tick_bcd_stopwatch: counts timer ticks in 4-digit BCD with run/clear buttons
// and drives a multiplexed active-low 7-segment display.
module tick_bcd_stopwatch
  import tick_bcd_stopwatch_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int SYNC_LEN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        btn_run,
  input  logic        btn_clr,
  output logic [15:0] count_bcd,
  output logic        running,
  output logic        overflow,
  output logic [3:0]  an,
  output logic [6:0]  seg
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [SYNC_LEN-1:0] run_sync_q, clr_sync_q;
  logic run_prev_q, clr_prev_q, run_ev, clr_ev;
  logic running_q, running_d, overflow_q, scan_tc;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic [DIGITS:0] carry;
  logic [3:0] digit [DIGITS];
  assign run_ev = run_sync_q[SYNC_LEN-1] & ~run_prev_q;
  assign clr_ev = clr_sync_q[SYNC_LEN-1] & ~clr_prev_q;
  // a clear blocks the increment so it can never produce an overflow pulse
  assign carry[0] = tick & running_q & ~clr_ev;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .clk(clk), .rst(rst), .inc_i(carry[i]), .clr_i(clr_ev),
      .q_o(digit[i]), .carry_o(carry[i+1])
    );
    assign count_bcd[4*i +: 4] = digit[i];
  end
  always_comb begin
    running_d = clr_ev ? 1'b0 : running_q ^ run_ev;
    scan_tc = scan_cnt_q == CW'(SCAN_DIV - 1);
    scan_cnt_d = scan_tc ? '0 : scan_cnt_q + 1'b1;
    idx_d = idx_q + {1'b0, scan_tc};
    an_d = AN_IDLE ^ (4'b0001 << idx_d);
    seg_d = seg_enc(digit[idx_d]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      run_sync_q <= '0;
      clr_sync_q <= '0;
      run_prev_q <= 1'b0;
      clr_prev_q <= 1'b0;
      running_q <= 1'b0;
      overflow_q <= 1'b0;
      scan_cnt_q <= '0;
      idx_q <= 2'd0;
      an_q <= 4'b1110;
      seg_q <= SEG_0;
    end else begin
      run_sync_q <= {run_sync_q[SYNC_LEN-2:0], btn_run};
      clr_sync_q <= {clr_sync_q[SYNC_LEN-2:0], btn_clr};
      run_prev_q <= run_sync_q[SYNC_LEN-1];
      clr_prev_q <= clr_sync_q[SYNC_LEN-1];
      running_q <= running_d;
      overflow_q <= carry[DIGITS];
      scan_cnt_q <= scan_cnt_d;
      idx_q <= idx_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  assign running = running_q;
  assign overflow = overflow_q;
  assign an = an_q;
  assign seg = seg_q;
endmodule
